bus_uart_tx: RTL and testbench

BUS_UART_TX -- requirements
Module: bus_uart_tx

---
 rtl/bus_uart_tx.sv | 212 +++++++++++++++++++++
 tb/tb_bus_uart_tx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/bus_uart_tx.sv
// rtl/bus_uart_tx.sv - register-mapped UART transmitter with TX FIFO
//
// Writes to address 0x0 (TXDATA) push wr_data[7:0] into the TX FIFO.
// Writes to 0x4 (CTRL) set enable from wr_data[0].
// Any other address gets a decode-error response and has no other effect.
// A serializer drains the FIFO as 8N1 frames, LSB first.
// Define BUS_UART_TX_PARITY_EN to insert an even-parity bit, giving 8E1 frames.
//
// Ports:
//   clk, rst_n          clock (rising edge) and synchronous active-low reset
//   wr_valid/wr_ready   write request handshake; wr_addr, wr_data request payload
//   resp_valid/ready    write response handshake; resp_err = 1 for decode error
//   tx                  registered serial output, idle high
//   busy                FIFO non-empty or frame in progress
module bus_uart_tx #(
  parameter int FIFO_DEPTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_err,
  output logic        tx,
  output logic        busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CLK_W = $clog2(CLKS_PER_BIT);
  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

`ifdef BUS_UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic             rdy_q, rdy_d;
  logic             resp_valid_q, resp_valid_d;
  logic             resp_err_q, resp_err_d;
  logic             enable_q, enable_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;
  logic [CLK_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
`ifdef BUS_UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic is_txdata, is_ctrl, fifo_full, fifo_empty, accept, push, pop, bit_end;
  logic unused_ok;

  assign unused_ok = ^wr_data[31:8];

  always_comb begin
    is_txdata  = (wr_addr == 32'h0);
    is_ctrl    = (wr_addr == 32'h4);
    fifo_full  = (count_q == CNT_FULL);
    fifo_empty = (count_q == '0);
    // Only a TXDATA write waits for FIFO space; CTRL and errors never stall.
    wr_ready   = rdy_q & ~resp_valid_q & ~(is_txdata & fifo_full);
    accept     = wr_valid & wr_ready;
    push       = accept & is_txdata;
    bit_end    = (clk_cnt_q == CLK_LAST);

    rdy_d        = 1'b1;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    enable_d     = enable_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tx_d         = tx_q;
`ifdef BUS_UART_TX_PARITY_EN
    parity_d     = parity_q;
`endif
    pop          = 1'b0;
    clk_cnt_d    = (state_q == S_IDLE || bit_end) ? '0 : clk_cnt_q + CLK_W'(1);

    if (accept) begin
      resp_valid_d = 1'b1;
      resp_err_d   = ~(is_txdata | is_ctrl);
      if (is_ctrl) enable_d = wr_data[0];
    end else if (resp_valid_q && resp_ready) begin
      resp_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (enable_q && !fifo_empty) begin
          pop     = 1'b1;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == 3'd7) begin
`ifdef BUS_UART_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_q;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end
      end
`ifdef BUS_UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit to avoid an idle gap.
          if (enable_q && !fifo_empty) begin
            pop     = 1'b1;
            state_d = S_START;
            tx_d    = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pop) begin
      shift_d  = mem_q[rd_ptr_q];
`ifdef BUS_UART_TX_PARITY_EN
      parity_d = ^mem_q[rd_ptr_q];
`endif
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdy_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      enable_q     <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= S_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
`ifdef BUS_UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else begin
      rdy_q        <= rdy_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      enable_q     <= enable_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_q         <= tx_d;
`ifdef BUS_UART_TX_PARITY_EN
      parity_q     <= parity_d;
`endif
    end
  end

  // Storage needs no reset: the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data[7:0];
  end

  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign tx         = tx_q;
  assign busy       = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_uart_tx.sv
// tb/tb_bus_uart_tx.sv - directed self-checking bench for bus_uart_tx
module tb_bus_uart_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_err;
  logic        tx;
  logic        busy;

  int n_checks = 0;
  int n_fail = 0;

`ifdef BUS_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  bus_uart_tx #(.FIFO_DEPTH(8), .CLKS_PER_BIT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err),
    .tx(tx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge. Waits for acceptance, checks the response,
  // optionally holds resp_ready low for 'hold' cycles, then completes.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                           input int hold, input logic exp_err);
    int n = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    #1;
    while (!wr_ready && n < 2000) begin
      @(negedge clk); #1; n++;
    end
    chk("wr_accept", {31'b0, wr_ready}, 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
    chk("resp_valid", {31'b0, resp_valid}, 32'd1);
    chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_resp_valid", {31'b0, resp_valid}, 32'd1);
      chk("hold_resp_err", {31'b0, resp_err}, {31'b0, exp_err});
      chk("hold_wr_ready", {31'b0, wr_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_done", {31'b0, resp_valid}, 32'd0);
  endtask

  // Polls at each negedge until the start bit appears; returns found flag.
  task automatic wait_start(output bit found);
    int n = 0;
    while (tx !== 1'b0 && n < 3000) begin
      @(negedge clk); n++;
    end
    found = (tx === 1'b0);
    chk("start_found", {31'b0, found}, 32'd1);
  endtask

  // Checks tx on every cycle of one frame. If chained, the call must land on
  // the first cycle of the start bit (no idle gap allowed).
  task automatic rx_frame(input logic [7:0] b, input bit chained);
    logic [10:0] bits;
    bit found;
`ifdef BUS_UART_TX_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
`else
    bits = {1'b0, 1'b1, b, 1'b0};
`endif
    if (!chained) wait_start(found);
    for (int c = 0; c < NB * 16; c++) begin
      chk($sformatf("tx_%02h_c%0d", b, c), {31'b0, tx}, {31'b0, bits[c / 16]});
      @(negedge clk);
    end
  endtask

  initial begin
    bit found;
    int bad;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'b0, tx}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_wr_ready", {31'b0, wr_ready}, 32'd1);

    // Single frame 0x41
    fork
      bus_write(32'h0, 32'h41, 0, 1'b0);
      rx_frame(8'h41, 1'b0);
    join
    chk("after_41_busy", {31'b0, busy}, 32'd0);
    chk("after_41_tx", {31'b0, tx}, 32'd1);

    // Decode error: no side effect
    bus_write(32'h8, 32'h0, 0, 1'b1);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("err_no_effect", bad, 0);

    // Response held off for 5 cycles
    bus_write(32'hC, 32'h1, 5, 1'b1);

    // Fill FIFO while disabled, 9th stalls, enable and stream back-to-back
    bus_write(32'h4, 32'h0, 0, 1'b0);
    for (int i = 0; i < 8; i++) bus_write(32'h0, 32'h30 + i, 0, 1'b0);
    chk("full_busy", {31'b0, busy}, 32'd1);
    chk("full_tx_idle", {31'b0, tx}, 32'd1);
    wr_valid = 1'b1; wr_addr = 32'h0; wr_data = 32'h38;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_stall", {31'b0, wr_ready}, 32'd0);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    fork
      begin
        bus_write(32'h4, 32'h1, 0, 1'b0);
        bus_write(32'h0, 32'h38, 0, 1'b0);
      end
      begin
        rx_frame(8'h30, 1'b0);
        for (int i = 1; i < 9; i++) rx_frame(8'h30 + 8'(i), 1'b1);
      end
    join
    chk("stream_done_busy", {31'b0, busy}, 32'd0);

`ifdef BUS_UART_TX_PARITY_EN
    fork
      bus_write(32'h0, 32'h07, 0, 1'b0);
      rx_frame(8'h07, 1'b0);
    join
    fork
      bus_write(32'h0, 32'h03, 0, 1'b0);
      rx_frame(8'h03, 1'b0);
    join
`endif

    // Reset during data bit 3 of 0x55 with two bytes queued behind it
    bus_write(32'h4, 32'h0, 0, 1'b0);
    bus_write(32'h0, 32'h55, 0, 1'b0);
    bus_write(32'h0, 32'hAA, 0, 1'b0);
    bus_write(32'h0, 32'h11, 0, 1'b0);
    fork
      bus_write(32'h4, 32'h1, 0, 1'b0);
      begin
        wait_start(found);
        repeat (16 * 4 + 5) @(negedge clk);
      end
    join
    chk("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_tx", {31'b0, tx}, 32'd1);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_wr_ready", {31'b0, wr_ready}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_release_ready", {31'b0, wr_ready}, 32'd1);
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("midrst_no_frames", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
